regfile_writeback: RTL and testbench

- Writer side of the 32-entry integer register file. It arbitrates write results from the single-cycle ALU path and the multi-cycle memory/mul path.
- Memory-path results are buffered in a small FIFO.
- It drives a single registered write port (rd, rd_in, rd_we) into the register file.
- A per-register pending scoreboard gives the issue stage a read-after-write hazard signal.

---
 rtl/regfile_writeback_if.sv | 35 +++
 rtl/regfile_writeback.sv | 132 +++++++++++++
 tb/tb_regfile_writeback.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Bundle of the writeback block's result, issue-check and register-file port signals.
// The block itself takes the slave modport; the producer side takes the master modport.
interface regfile_writeback_if #(
    parameter int XLEN = 64
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic            hazard;
    logic [31:0]     pend_mask;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_in;
    logic            rd_we;
    logic            waw_err;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               iss_valid, iss_rd, chk_rs1, chk_rs2,
        input  mem_ready, hazard, pend_mask, rd, rd_in, rd_we, waw_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               iss_valid, iss_rd, chk_rs1, chk_rs2,
        output mem_ready, hazard, pend_mask, rd, rd_in, rd_we, waw_err
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writer: ALU results take priority over a FIFO of memory-path results.
// A pending scoreboard flags read-after-write hazards to the issue stage.
module regfile_writeback #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    regfile_writeback_if.slave bus
);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count;
    logic            init_q;
    logic [31:0]     pend_q, pend_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rd_in_q, rd_in_d;
    logic            rd_we_q, rd_we_d;
    logic            waw_q, waw_d;

    logic   push, pop, alu_take, fifo_empty;
    entry_t head;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    // init_q keeps mem_ready low until the first clock after reset release.
    assign bus.mem_ready = init_q && (count < DEPTH_C);
    assign push          = bus.mem_valid && bus.mem_ready;
    assign alu_take      = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign pop           = !alu_take && !fifo_empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_d     = rd_q;
        rd_in_d  = rd_in_q;
        rd_we_d  = 1'b0;
        pend_d   = pend_q;
        waw_d    = waw_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if ((alu_take && pend_q[bus.alu_rd]) ||
            (bus.iss_valid && (bus.iss_rd != 5'd0) && pend_q[bus.iss_rd])) begin
            waw_d = 1'b1;
        end

        if (alu_take) begin
            rd_d    = bus.alu_rd;
            rd_in_d = bus.alu_data;
            rd_we_d = 1'b1;
        end else if (pop) begin
            rd_ptr_d           = rd_ptr_q + 1'b1;
            pend_d[head.rd]    = 1'b0;
            if (head.rd != 5'd0) begin
                rd_d    = head.rd;
                rd_in_d = head.data;
                rd_we_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        // Applied after the clear so a same-edge set of the same register wins.
        if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
            pend_d[bus.iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            init_q   <= 1'b0;
            pend_q   <= '0;
            rd_q     <= '0;
            rd_in_q  <= '0;
            rd_we_q  <= 1'b0;
            waw_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            init_q   <= 1'b1;
            pend_q   <= pend_d;
            rd_q     <= rd_d;
            rd_in_q  <= rd_in_d;
            rd_we_q  <= rd_we_d;
            waw_q    <= waw_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= '{rd: bus.mem_rd, data: bus.mem_data};
        end
    end

    // The port-stage write is not yet readable from the register file, so it counts as pending.
    always_comb begin
        bus.hazard = 1'b0;
        if ((bus.chk_rs1 != 5'd0) &&
            (pend_q[bus.chk_rs1] || (rd_we_q && (rd_q == bus.chk_rs1)))) begin
            bus.hazard = 1'b1;
        end
        if ((bus.chk_rs2 != 5'd0) &&
            (pend_q[bus.chk_rs2] || (rd_we_q && (rd_q == bus.chk_rs2)))) begin
            bus.hazard = 1'b1;
        end
    end

    assign bus.pend_mask = pend_q;
    assign bus.rd        = rd_q;
    assign bus.rd_in     = rd_in_q;
    assign bus.rd_we     = rd_we_q;
    assign bus.waw_err   = waw_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and randomized bench for regfile_writeback against a queue-based reference model.
// Combinational outputs are checked before each edge, registered outputs 1 ns after it.
module tb_regfile_writeback;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_writeback_if #(.XLEN(XLEN)) bus ();

    regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit [31:0]   m_pend;
    logic [4:0]  m_rd;
    logic [63:0] m_in;
    bit          m_we;
    bit          m_waw;
    bit          m_init;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_pend = '0;
        m_rd   = '0;
        m_in   = '0;
        m_we   = 1'b0;
        m_waw  = 1'b0;
        m_init = 1'b0;
    endfunction

    function automatic bit m_ready();
        return m_init && (m_q.size() < DEPTH);
    endfunction

    function automatic bit m_hazard(input logic [4:0] r1, input logic [4:0] r2);
        bit h = 1'b0;
        if (r1 != 0 && (m_pend[r1] || (m_we && m_rd == r1))) h = 1'b1;
        if (r2 != 0 && (m_pend[r2] || (m_we && m_rd == r2))) h = 1'b1;
        return h;
    endfunction

    // One clock of the reference: decide this edge's writeback from the pre-edge state.
    function automatic void m_clock(input bit av, input logic [4:0] ard, input logic [63:0] adat,
                                    input bit mv, input logic [4:0] mrd, input logic [63:0] mdat,
                                    input bit iv, input logic [4:0] ird);
        bit   do_push = mv && m_ready();
        bit   alu_ok  = av && ard != 0;
        ent_t e;
        if ((alu_ok && m_pend[ard]) || (iv && ird != 0 && m_pend[ird])) m_waw = 1'b1;
        m_we = 1'b0;
        if (alu_ok) begin
            m_rd = ard;
            m_in = adat;
            m_we = 1'b1;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_pend[e.rd] = 1'b0;
            if (e.rd != 0) begin
                m_rd = e.rd;
                m_in = e.data;
                m_we = 1'b1;
            end
        end
        if (do_push) m_q.push_back('{rd: mrd, data: mdat});
        if (iv && ird != 0) m_pend[ird] = 1'b1;
        m_pend[0] = 1'b0;
        m_init = 1'b1;
    endfunction

    task automatic step(input bit av, input logic [4:0] ard, input logic [63:0] adat,
                        input bit mv, input logic [4:0] mrd, input logic [63:0] mdat,
                        input bit iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = adat;
        bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = mdat;
        bus.iss_valid = iv;  bus.iss_rd = ird;
        bus.chk_rs1   = r1;  bus.chk_rs2 = r2;
        #1;
        check("mem_ready", 64'(bus.mem_ready), 64'(m_ready()));
        check("hazard", 64'(bus.hazard), 64'(m_hazard(r1, r2)));
        m_clock(av, ard, adat, mv, mrd, mdat, iv, ird);
        @(posedge clk);
        #1;
        check("rd_we", 64'(bus.rd_we), 64'(m_we));
        check("rd", 64'(bus.rd), 64'(m_rd));
        check("rd_in", bus.rd_in, m_in);
        check("pend_mask", 64'(bus.pend_mask), 64'(m_pend));
        check("waw_err", 64'(bus.waw_err), 64'(m_waw));
    endtask

    task automatic idle(input logic [4:0] r1);
        step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    initial begin
        m_reset();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
        bus.iss_valid = 0; bus.iss_rd = 0; bus.chk_rs1 = 0; bus.chk_rs2 = 0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_we", 64'(bus.rd_we), 64'd0);
        check("rst_rd", 64'(bus.rd), 64'd0);
        check("rst_rd_in", bus.rd_in, 64'd0);
        check("rst_pend", 64'(bus.pend_mask), 64'd0);
        check("rst_waw", 64'(bus.waw_err), 64'd0);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single ALU write, visible one edge later, then the enable drops.
        step(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
        check("alu_rd", 64'(bus.rd), 64'd5);
        check("alu_data", bus.rd_in, 64'h1234);
        check("alu_we", 64'(bus.rd_we), 64'd1);
        idle(0);
        check("alu_we_drop", 64'(bus.rd_we), 64'd0);

        // Pending r7 cleared by its memory result; hazard lingers one cycle via the port.
        step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        check("pend_r7", 64'(bus.pend_mask), 64'h80);
        check("haz_pend", 64'(bus.hazard), 64'd1);
        step(0, 0, 0, 1, 7, 64'hAA, 0, 0, 7, 0);
        idle(7);
        check("pop_pend", 64'(bus.pend_mask), 64'd0);
        check("pop_rd", 64'(bus.rd), 64'd7);
        check("pop_data", bus.rd_in, 64'hAA);
        check("haz_port", 64'(bus.hazard), 64'd1);
        idle(7);
        idle(7);
        check("haz_clear", 64'(bus.hazard), 64'd0);

        // ALU stream starves the FIFO until it fills; then drain in push order.
        for (int i = 0; i < 6; i++)
            step(1, 5'(i % 4 + 1), 64'(100 + i), 1, 5'(10 + i), 64'(64'hB00 + i), 0, 0, 0, 0);
        check("fifo_full_ready", 64'(bus.mem_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(0);
            check("drain_rd", 64'(bus.rd), 64'(10 + i));
            check("drain_data", bus.rd_in, 64'hB00 + 64'(i));
        end
        idle(0);

        // Writes to x0 from either path never reach the port.
        step(1, 0, 64'h55, 1, 0, 64'h66, 0, 0, 0, 0);
        check("x0_alu_we", 64'(bus.rd_we), 64'd0);
        step(1, 0, 64'h77, 0, 0, 0, 0, 0, 0, 0);
        check("x0_mem_we", 64'(bus.rd_we), 64'd0);
        idle(0);

        // ALU write to a pending register raises the sticky error.
        step(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        step(1, 3, 64'h33, 0, 0, 0, 0, 0, 0, 0);
        check("waw_set", 64'(bus.waw_err), 64'd1);
        for (int i = 0; i < 300; i++)
            step(($urandom % 2) == 0, 5'($urandom % 8), {$urandom, $urandom},
                 ($urandom % 2) == 0, 5'($urandom % 8), {$urandom, $urandom},
                 ($urandom % 8) == 0, 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8));
        check("waw_sticky", 64'(bus.waw_err), 64'd1);

        // Asynchronous reset mid-cycle with three entries queued.
        for (int i = 0; i < 8; i++) idle(0);
        step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 1, 64'(i), 1, 5'(20 + i), 64'(64'hC0 + i), 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("mid_rst_we", 64'(bus.rd_we), 64'd0);
        check("mid_rst_ready", 64'(bus.mem_ready), 64'd0);
        check("mid_rst_pend", 64'(bus.pend_mask), 64'd0);
        check("mid_rst_waw", 64'(bus.waw_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(0);
            check("no_stale_we", 64'(bus.rd_we), 64'd0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++)
            step(($urandom % 3) == 0, 5'($urandom % 16), {$urandom, $urandom},
                 ($urandom % 2) == 0, 5'($urandom % 16), {$urandom, $urandom},
                 ($urandom % 6) == 0, 5'($urandom % 16), 5'($urandom % 16), 5'($urandom % 16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
